psum_accumulator: RTL

- Downstream consumer of the 16-lane x 20-bit partial-sum FIFO (FIFO_16x16x20b) at the systolic array output.
- Sums per-row partial sums across a configurable number of K-tile passes into a local row buffer of 16 lanes x 32 bits.
- Then drains the finished rows to the result writer over a valid/ready handshake.

---
 rtl/psum_accumulator_pkg.sv | 17 +
 rtl/acc_row_buffer.sv | 30 +++
 rtl/psum_accumulator.sv | 107 ++++++++++
 3 files changed

// File: rtl/psum_accumulator_pkg.sv
// Shared sizing, state encodings and bench timing constants for the partial-sum accumulator.
package psum_accumulator_pkg;
    localparam int LANES  = 16;
    localparam int PSUM_W = 20;
    localparam int ACC_W  = 32;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ACCUM      = 2'd1;
    localparam logic [1:0] DRAIN_LOAD = 2'd2;
    localparam logic [1:0] DRAIN      = 2'd3;

    localparam int clock_period      = 10;
    localparam int half_clock_period = clock_period / 2;
    localparam int minimum_period    = 2;
endpackage

// File: rtl/acc_row_buffer.sv
// Row buffer: DEPTH rows of LANES accumulators, one combinational read and one synchronous write.
module acc_row_buffer
    import psum_accumulator_pkg::*;
(
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic                    first_pass,
    input  logic [PTR_W-1:0]        addr,
    input  logic [LANES*PSUM_W-1:0] in_data,
    output logic [LANES*ACC_W-1:0]  rd_data
);
    logic [LANES*ACC_W-1:0] mem [DEPTH];
    logic [LANES*ACC_W-1:0] wr_data;

    // Read and write share the address, so accumulation is a read-modify-write of the same row.
    assign rd_data = mem[addr];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int IN_LO  = (LANES - 1 - i) * PSUM_W;
        localparam int ACC_LO = (LANES - 1 - i) * ACC_W;
        logic [ACC_W-1:0] ext;
        assign ext = {{(ACC_W-PSUM_W){in_data[IN_LO+PSUM_W-1]}}, in_data[IN_LO +: PSUM_W]};
        assign wr_data[ACC_LO +: ACC_W] = first_pass ? ext : rd_data[ACC_LO +: ACC_W] + ext;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[addr] <= wr_data;
    end
endmodule

// File: rtl/psum_accumulator.sv
// Accumulates partial-sum rows over K-tile passes, then drains the finished rows over valid/ready.
module psum_accumulator
    import psum_accumulator_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [4:0]              cfg_rows,
    input  logic [7:0]              cfg_passes,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*PSUM_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACC_W-1:0]  out_data,
    output logic                    busy,
    output logic                    done
);
    logic [1:0]             state;
    logic [PTR_W:0]         rows;
    logic [PTR_W:0]         row_ptr;
    logic [7:0]             passes;
    logic [7:0]             pass_cnt;
    logic [LANES*ACC_W-1:0] rd_data;
    logic                   accept;
    logic                   last_row;
    logic                   handshake;

    assign accept    = (state == ACCUM) && in_valid && in_ready;
    assign last_row  = (row_ptr == rows - 1'b1);
    assign handshake = (state == DRAIN) && out_valid && out_ready;

    // row_ptr runs one past the last row during drain; its low bits then alias row 0 harmlessly.
    acc_row_buffer u_buf (
        .clk        (clk),
        .wr_en      (accept),
        .first_pass (pass_cnt == 8'd0),
        .addr       (row_ptr[PTR_W-1:0]),
        .in_data    (in_data),
        .rd_data    (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            row_ptr   <= '0;
            pass_cnt  <= '0;
            rows      <= '0;
            passes    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Zero (or anything past DEPTH) selects a full buffer.
                        rows     <= (cfg_rows == 5'd0 || cfg_rows > 5'(DEPTH)) ? (PTR_W+1)'(DEPTH)
                                                                                : cfg_rows[PTR_W:0];
                        passes   <= (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
                        row_ptr  <= '0;
                        pass_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (last_row) begin
                            row_ptr  <= '0;
                            pass_cnt <= pass_cnt + 8'd1;
                            if (pass_cnt == passes - 8'd1) begin
                                in_ready <= 1'b0;
                                state    <= DRAIN_LOAD;
                            end
                        end else begin
                            row_ptr <= row_ptr + 1'b1;
                        end
                    end
                end
                DRAIN_LOAD: begin
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
                    row_ptr   <= (PTR_W+1)'(1);
                    state     <= DRAIN;
                end
                default: begin
                    if (handshake) begin
                        if (row_ptr == rows) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_data <= rd_data;
                            row_ptr  <= row_ptr + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule
